// File: rtl/grid_pkg.sv
// Shared constants, state encoding and init-pattern helper for the Tetris playfield RAM.
package grid_pkg;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int DEPTH      = 256;
  localparam int LINE_WIDTH = 10;

  localparam logic [3:0]        LINE_OFFSET = 4'd12;
  localparam logic [3:0]        COL_LAST    = 4'd11;
  localparam logic [4:0]        NUM_ROWS    = 5'd20;
  localparam logic [DATA_W-1:0] WALL_VAL    = 8'hFF;
  localparam logic [DATA_W-1:0] AIR         = 8'h00;
  localparam logic [ADDR_W-1:0] FLOOR_BASE  = 8'd240;
  localparam logic [ADDR_W-1:0] ADDR_LAST   = 8'd255;

  typedef enum logic {INIT, SERVE} grid_state_t;

  // Rows past the floor (addr 252..255) are padding and stay air.
  function automatic logic [DATA_W-1:0] init_cell(logic [3:0] col, logic [4:0] row);
    if (row == NUM_ROWS)
      return WALL_VAL;
    if (row < NUM_ROWS && (col == 4'd0 || col == COL_LAST))
      return WALL_VAL;
    return AIR;
  endfunction
endpackage

// File: rtl/grid_memory_if.sv
// Client-side bus of the playfield memory: clearer, placer, renderer and game control.
interface grid_memory_if;
  import grid_pkg::*;

  logic              new_game;
  logic              busy;
  logic              clr_sel;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;
  logic [DATA_W-1:0] clr_wdata;
  logic [DATA_W-1:0] clr_rdata;
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_wdata;
  logic              pl_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_stall;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_rdata;

  modport master (
    output new_game, clr_sel, clr_addr, clr_we, clr_wdata,
           pl_we, pl_addr, pl_wdata, rd_req, rd_addr,
    input  busy, clr_rdata, pl_ack, rd_stall, rd_valid, rd_rdata
  );

  modport slave (
    input  new_game, clr_sel, clr_addr, clr_we, clr_wdata,
           pl_we, pl_addr, pl_wdata, rd_req, rd_addr,
    output busy, clr_rdata, pl_ack, rd_stall, rd_valid, rd_rdata
  );
endinterface

// File: rtl/grid_ram.sv
// Single-port synchronous RAM with registered read data; kept separate so it can be swapped for a macro.
module grid_ram #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int NW = 256
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:NW-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we)
        mem[addr] <= wdata;
      else
        rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/grid_memory.sv
// Playfield memory: self-initialising wall/floor sequencer plus fixed-priority
// single-access arbiter (clearer > placer > renderer).
module grid_memory
  import grid_pkg::*;
(
  input logic         clk,
  input logic         rst,
  grid_memory_if.slave bus
);
  grid_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        col_q;
  logic [4:0]        row_q;
  logic              cnt_clr, cnt_inc;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic              clr_rd_d, clr_rd_q, rd_d, rd_q;
  logic [DATA_W-1:0] clr_hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      clr_rd_q   <= 1'b0;
      rd_q       <= 1'b0;
      clr_hold_q <= AIR;
    end else begin
      state_q  <= state_d;
      clr_rd_q <= clr_rd_d;
      rd_q     <= rd_d;
      if (clr_rd_q)
        clr_hold_q <= ram_rdata;
      if (cnt_clr) begin
        addr_q <= '0;
        col_q  <= '0;
        row_q  <= '0;
      end else if (cnt_inc) begin
        addr_q <= addr_q + 8'd1;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 5'd1;
        end else begin
          col_q <= col_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = addr_q;
    ram_wdata    = AIR;
    clr_rd_d     = 1'b0;
    rd_d         = 1'b0;
    bus.pl_ack   = 1'b0;
    bus.rd_stall = bus.rd_req;

    if (bus.new_game) begin
      state_d = INIT;
      cnt_clr = 1'b1;
    end else if (state_q == INIT) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_wdata = init_cell(col_q, row_q);
      cnt_inc   = 1'b1;
      if (addr_q == ADDR_LAST)
        state_d = SERVE;
    end else if (bus.clr_sel) begin
      ram_en    = 1'b1;
      ram_addr  = bus.clr_addr;
      ram_we    = bus.clr_we && (bus.clr_addr < FLOOR_BASE);
      ram_wdata = bus.clr_wdata;
      clr_rd_d  = !bus.clr_we;
    end else if (bus.pl_we) begin
      // Floor writes are swallowed but still acknowledged so the placer moves on.
      bus.pl_ack = 1'b1;
      ram_en     = bus.pl_addr < FLOOR_BASE;
      ram_we     = 1'b1;
      ram_addr   = bus.pl_addr;
      ram_wdata  = bus.pl_wdata;
    end else if (bus.rd_req) begin
      bus.rd_stall = 1'b0;
      ram_en       = 1'b1;
      ram_addr     = bus.rd_addr;
      rd_d         = 1'b1;
    end
  end

  grid_ram #(.AW(ADDR_W), .DW(DATA_W), .NW(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.busy      = (state_q == INIT);
  assign bus.clr_rdata = clr_rd_q ? ram_rdata : clr_hold_q;
  assign bus.rd_valid  = rd_q;
  assign bus.rd_rdata  = rd_q ? ram_rdata : AIR;
endmodule
